// File: rtl/crc_data_gen_pkg.sv
// Shared definitions for the CRC-16 data generator and its matching checker.
package crc_data_gen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SOP  = 3'd1,
    DATA = 3'd2,
    CRC  = 3'd3,
    EOP  = 3'd4
  } state_t;

  localparam logic [15:0] CRC_POLY          = 16'h1021;
  localparam logic [15:0] CRC_INIT          = 16'hFFFF;
  localparam int          DEFAULT_MAX_WORDS = 256;

endpackage

// File: rtl/crc16_d32.sv
// One-step CRC-16 (poly 0x1021, MSB-first) over a full 32-bit word.
module crc16_d32
  import crc_data_gen_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [31:0] data,
  output logic [15:0] crcNext
);

  logic [15:0] crcWork;

  always_comb begin
    crcWork = crc;
    for (int i = 31; i >= 0; i--) begin
      crcWork = {crcWork[14:0], 1'b0} ^ ((crcWork[15] ^ data[i]) ? CRC_POLY : 16'h0000);
    end
  end

  assign crcNext = crcWork;

endmodule

// File: rtl/crc_data_gen.sv
// Packet generator: forwards data words with 1-cycle latency and appends a CRC-16 word.
module crc_data_gen
  import crc_data_gen_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iWrSop,
  input  logic        iWrEop,
  input  logic        iWrVld,
  input  logic [31:0] iWrData,
  output logic        oWrReady,
  output logic        oTxSop,
  output logic        oTxEop,
  output logic        oTxVld,
  output logic        oTxLast,
  output logic [31:0] oTxData,
  input  logic        iReady,
  output logic        oErr
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  state_t        state;
  logic [15:0]   crcReg;
  logic [15:0]   crcNext;
  logic [CW-1:0] wordCnt;
  logic          wrXfer;
  logic          drain;

  assign oWrReady = (state == DATA) && (!oTxVld || iReady);
  // A word presented together with EOP is never consumed.
  assign wrXfer   = iWrVld && oWrReady && !iWrEop;
  assign drain    = oTxVld && iReady;

  crc16_d32 uCrc (
    .crc     (crcReg),
    .data    (iWrData),
    .crcNext (crcNext)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      crcReg  <= CRC_INIT;
      wordCnt <= '0;
      oTxSop  <= 1'b0;
      oTxEop  <= 1'b0;
      oTxVld  <= 1'b0;
      oTxLast <= 1'b0;
      oTxData <= '0;
      oErr    <= 1'b0;
    end else begin
      oTxSop <= 1'b0;
      oTxEop <= 1'b0;
      if (drain) begin
        oTxVld  <= 1'b0;
        oTxLast <= 1'b0;
      end
      if (iWrSop && state != IDLE) oErr <= 1'b1;

      case (state)
        IDLE: begin
          if (iWrVld) oErr <= 1'b1;
          if (iWrSop) begin
            crcReg  <= CRC_INIT;
            wordCnt <= '0;
            oTxSop  <= 1'b1;
            state   <= SOP;
          end
        end
        SOP: state <= DATA;
        DATA: begin
          if (iWrEop) begin
            if (iWrVld) oErr <= 1'b1;
            state <= CRC;
          end else if (wrXfer) begin
            if (wordCnt == CW'(MAX_WORDS)) begin
              oErr <= 1'b1;
            end else begin
              oTxData <= iWrData;
              oTxVld  <= 1'b1;
              crcReg  <= crcNext;
              wordCnt <= wordCnt + 1'b1;
            end
          end
        end
        CRC: begin
          // Load the CRC word as soon as the data slot is free, then wait for it to go.
          if (!oTxLast) begin
            if (!oTxVld || iReady) begin
              oTxData <= {16'h0000, crcReg};
              oTxVld  <= 1'b1;
              oTxLast <= 1'b1;
            end
          end else if (iReady) begin
            oTxEop <= 1'b1;
            state  <= EOP;
          end
        end
        EOP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc_data_gen.md
CRC_DATA_GEN -- requirements
Module: crc_data_gen

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the maximum number of data words per packet (1024 B / 4).
REQ-002 SHALL have port iClk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port iRst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port iWrSop, input, 1, one-cycle packet-start pulse.
REQ-005 SHALL have port iWrEop, input, 1, one-cycle packet-end pulse, issued after the last data word is accepted.
REQ-006 SHALL have port iWrVld, input, 1, data word valid.
REQ-007 SHALL have port iWrData, input, 32, data word; a partial tail word is zero-padded in its upper bytes.
REQ-008 SHALL have port oWrReady, output, 1, upstream may transfer; a word transfers on iWrVld & oWrReady.
REQ-009 SHALL have port oTxSop, output, 1, one-cycle start pulse to the downstream checker.
REQ-010 SHALL have port oTxEop, output, 1, one-cycle end pulse to the downstream checker.
REQ-011 SHALL have port oTxVld, output, 1, output word valid.
REQ-012 SHALL have port oTxLast, output, 1, marks the appended CRC word.
REQ-013 SHALL have port oTxData, output, 32, output word.
REQ-014 SHALL have port iReady, input, 1, downstream accepts; a word transfers on oTxVld & iReady.
REQ-015 SHALL have port oErr, output, 1, sticky protocol-error flag.

Function
REQ-016 SHALL implement an FSM with states IDLE, SOP, DATA, CRC and EOP.
REQ-017 IDLE: on iWrSop, SHALL load the CRC register with 0xFFFF, clear the word counter and enter SOP.
REQ-018 SOP: SHALL drive oTxSop=1 for exactly one cycle, then enter DATA.
REQ-019 DATA: SHALL drive oWrReady = !oTxVld | iReady; oWrReady SHALL be 0 in every other state.
REQ-020 SHALL register each accepted word onto oTxData/oTxVld in the next cycle (latency 1).
REQ-021 SHALL update the CRC with each accepted word in the same cycle.
REQ-022 SHALL hold oTxData/oTxVld stable while oTxVld & !iReady; no word is dropped or duplicated.
REQ-023 CRC SHALL be CRC-16, polynomial 0x1021, init 0xFFFF, no reflection, no final XOR, applied to all 32 bits of each word MSB-first, padding included.
REQ-024 DATA: on iWrEop, SHALL enter CRC; an iWrVld in the same cycle as iWrEop SHALL be ignored and SHALL set oErr.
REQ-025 CRC: once the data register has drained, SHALL present oTxData={16'h0000, crc}, oTxVld=1, oTxLast=1.
REQ-026 CRC: SHALL hold the CRC word until iReady, then enter EOP.
REQ-027 EOP: SHALL drive oTxEop=1 for one cycle, then enter IDLE.
REQ-028 A packet with zero data words SHALL still emit SOP, the CRC word 0x0000FFFF, and EOP.
REQ-029 SHALL set oErr on any of: iWrSop outside IDLE (ignored), iWrVld in IDLE (ignored), or a word count exceeding MAX_WORDS (the excess words are dropped, with oWrReady still 1).
REQ-030 oErr SHALL clear only on reset.
REQ-031 iWrSop and iWrEop together in IDLE: SOP SHALL take priority and EOP SHALL be ignored.
REQ-032 iReady SHALL be ignored whenever oTxVld=0.

Reset
REQ-033 While iRst=1, SHALL force state IDLE, CRC register 0xFFFF, counter 0, oWrReady=0, oTxSop=oTxEop=oTxVld=oTxLast=0, oTxData=0 and oErr=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet with no EOP emitted; the next iWrSop after reset SHALL start cleanly.

Structure
REQ-035 Shared package/define file SHALL hold: the FSM state encodings, CRC_POLY=0x1021, CRC_INIT=0xFFFF, and the default MAX_WORDS.
REQ-036 SHALL use one combinational sub-module, crc16_d32 (inputs: crc[15:0], data[31:0]; output: next crc[15:0]), shared with the checker side.

Verification
REQ-037 Empty packet: SOP then EOP, iReady=1 -> oTxSop, then one word 0x0000FFFF with oTxLast=1, then oTxEop.
REQ-038 64-byte packet (16 random words), iReady=1 -> 16 words unchanged at 1-cycle latency, then the CRC word equal to the golden-model value.
REQ-039 Same 64-byte packet with iReady random 50% -> identical output word sequence; no word lost or repeated; oTxData stable while stalled.
REQ-040 65-byte packet (tail word 0x000000AB) -> 17 data words, then the golden CRC word; generator output fed to the checker gives checker error 0.
REQ-041 iWrSop during DATA, and 257 words with MAX_WORDS=256 -> oErr=1 and sticky; output still ends with CRC word and EOP.
REQ-042 iRst pulsed after 5 words of a packet -> all outputs 0 next cycle; a following 64-byte packet passes the REQ-038 check.
